mem_arbiter: RTL and testbench

- Shares the single banked main-memory port between the I-cache and D-cache fill/writeback controllers.
- Arbitrates line-sized burst requests round-robin, then issues one word per beat to memory.
- Tracks fixed-latency read returns, routes data to the owning requester, and signals completion.
- Sits in the memory hierarchy between both cache controllers and the main memory.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_rtrack.sv | 55 +++++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I/D cache to main-memory burst arbiter.
package mem_arb_pkg;

    localparam int DEF_BURST   = 4;
    localparam int DEF_MEM_LAT = 2;

    function automatic int beatWidth(input int burst);
        return (burst > 1) ? $clog2(burst) : 1;
    endfunction

    localparam int BEAT_W = beatWidth(DEF_BURST);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } arbState_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_rtrack.sv
// Read-return tracker: fixed-latency valid/beat pipe aligned with mem_rdata plus a return counter.
module mem_arb_rtrack
    import mem_arb_pkg::*;
#(
    parameter int  BURST   = DEF_BURST,
    parameter int  MEM_LAT = DEF_MEM_LAT,
    localparam int BW      = beatWidth(BURST)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic [BW-1:0] pushBeat,
    output logic          retValid,
    output logic [BW-1:0] retBeat,
    output logic          allReturned
);

    logic          vldSr  [MEM_LAT];
    logic [BW-1:0] beatSr [MEM_LAT];
    logic [BW-1:0] retCnt;

    // Latency pipe: shifts every cycle; the last stage coincides with valid mem_rdata.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < MEM_LAT; k++) begin
                vldSr[k]  <= 1'b0;
                beatSr[k] <= '0;
            end
        end else begin
            vldSr[0]  <= push;
            beatSr[0] <= pushBeat;
            for (int k = 1; k < MEM_LAT; k++) begin
                vldSr[k]  <= vldSr[k-1];
                beatSr[k] <= beatSr[k-1];
            end
        end
    end

    // Return counter wraps to zero on the final beat, so it is clean for the next burst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retCnt <= '0;
        end else if (clear) begin
            retCnt <= '0;
        end else if (retValid) begin
            retCnt <= retCnt + 1'b1;
        end
    end

    assign retValid    = vldSr[MEM_LAT-1];
    assign retBeat     = beatSr[MEM_LAT-1];
    assign allReturned = retValid && (retCnt == BW'(BURST - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the main-memory port between the I-cache and D-cache line controllers.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int  ADDR_W  = 16,
    parameter int  DATA_W  = 16,
    parameter int  BURST   = DEF_BURST,
    parameter int  MEM_LAT = DEF_MEM_LAT,
    localparam int BW      = beatWidth(BURST)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic [BW-1:0]     i_rbeat,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [BW-1:0]     d_wbeat,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [BW-1:0]     d_rbeat,
    output logic              d_done,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_stall
);

    // Beats are word-addressed on a byte bus, hence the extra cleared bit.
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-BW-1){1'b1}}, {(BW+1){1'b0}}};
    localparam logic [BW-1:0]     LAST_BEAT = BW'(BURST - 1);

    arbState_t         state, nextState;
    owner_t            owner, lastOwner;
    logic              isWr;
    logic [ADDR_W-1:0] base;
    logic [BW-1:0]     beat;
    logic              grantI, grantD;
    logic              inIssue, beatAccept;
    logic              retValid, allReturned;
    logic [BW-1:0]     retBeat;

    assign inIssue    = (state == ISSUE);
    assign beatAccept = inIssue && !mem_stall;

    // Burst context: owner, direction and line base are frozen at grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= OWN_I;
            lastOwner <= OWN_I;
            isWr      <= 1'b0;
            base      <= '0;
            beat      <= '0;
        end else begin
            state <= nextState;
            if (grantI || grantD) begin
                owner     <= grantD ? OWN_D : OWN_I;
                lastOwner <= grantD ? OWN_D : OWN_I;
                isWr      <= grantD && d_wr;
                base      <= grantD ? (d_addr & LINE_MASK) : (i_addr & LINE_MASK);
                beat      <= '0;
            end else if (beatAccept) begin
                beat <= beat + 1'b1;
            end
        end
    end

    // Arbitration and burst sequencing; requests are only looked at in IDLE.
    always_comb begin
        nextState = state;
        grantI    = 1'b0;
        grantD    = 1'b0;
        case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    if (lastOwner == OWN_D) begin
                        grantI = 1'b1;
                    end else begin
                        grantD = 1'b1;
                    end
                end else if (i_req) begin
                    grantI = 1'b1;
                end else if (d_req) begin
                    grantD = 1'b1;
                end else begin
                    grantI = 1'b0;
                end
                if (grantI || grantD) begin
                    nextState = ISSUE;
                end else begin
                    nextState = IDLE;
                end
            end
            ISSUE: begin
                if (beatAccept && (beat == LAST_BEAT)) begin
                    nextState = isWr ? DONE : DRAIN;
                end else begin
                    nextState = ISSUE;
                end
            end
            DRAIN: begin
                if (allReturned) begin
                    nextState = DONE;
                end else begin
                    nextState = DRAIN;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    mem_arb_rtrack #(
        .BURST   (BURST),
        .MEM_LAT (MEM_LAT)
    ) u_rtrack (
        .clk         (clk),
        .rst         (rst),
        .clear       (grantI || grantD),
        .push        (beatAccept && !isWr),
        .pushBeat    (beat),
        .retValid    (retValid),
        .retBeat     (retBeat),
        .allReturned (allReturned)
    );

    assign mem_rd    = inIssue && !isWr;
    assign mem_wr    = inIssue && isWr;
    assign mem_addr  = inIssue ? (base | (ADDR_W'(beat) << 1)) : '0;
    assign mem_wdata = (inIssue && isWr) ? d_wdata : '0;
    assign d_wbeat   = (inIssue && isWr && (owner == OWN_D)) ? beat : '0;

    assign i_gnt    = grantI;
    assign d_gnt    = grantD;
    assign i_rvalid = retValid && (owner == OWN_I);
    assign d_rvalid = retValid && (owner == OWN_D);
    assign i_rdata  = i_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;
    assign i_rbeat  = i_rvalid ? retBeat : '0;
    assign d_rbeat  = d_rvalid ? retBeat : '0;
    assign i_done   = (state == DONE) && (owner == OWN_I);
    assign d_done   = (state == DONE) && (owner == OWN_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed bursts push expected events, a negedge monitor checks them.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        int cyc;
        int a;
        int b;
        int c;
        int d;
    } ev_t;

    logic              clk;
    logic              rst;
    logic              i_req, d_req, d_wr, mem_stall;
    logic [15:0]       i_addr, d_addr, d_wdata, mem_rdata;
    logic              i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done, mem_rd, mem_wr;
    logic [15:0]       i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [BEAT_W-1:0] i_rbeat, d_rbeat, d_wbeat;

    ev_t gntQ[$];
    ev_t memQ[$];
    ev_t retQ[$];
    ev_t doneQ[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int t;

    logic [15:0] pipeA [DEF_MEM_LAT];
    logic        pipeV [DEF_MEM_LAT];

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .i_rbeat   (i_rbeat),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wbeat   (d_wbeat),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_rbeat   (d_rbeat),
        .d_done    (d_done),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_stall (mem_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Fixed-latency memory: returns addr ^ 0x5A5A MEM_LAT cycles after an accepted read.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEF_MEM_LAT; k++) begin
                pipeV[k] <= 1'b0;
                pipeA[k] <= 16'h0000;
            end
        end else begin
            pipeV[0] <= mem_rd && !mem_stall;
            pipeA[0] <= mem_addr;
            for (int k = 1; k < DEF_MEM_LAT; k++) begin
                pipeV[k] <= pipeV[k-1];
                pipeA[k] <= pipeA[k-1];
            end
        end
    end

    assign mem_rdata = pipeV[DEF_MEM_LAT-1] ? (pipeA[DEF_MEM_LAT-1] ^ 16'h5A5A) : 16'h0000;
    assign d_wdata   = 16'hC000 | 16'(d_wbeat);

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic checkIdle(input string name);
        check(name, $countones({i_gnt, i_rvalid, i_rdata, i_rbeat, i_done, d_wbeat, d_gnt,
                                d_rvalid, d_rdata, d_rbeat, d_done, mem_rd, mem_wr,
                                mem_addr, mem_wdata}), 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // side: 0 = I, 1 = D. stallBeat < 0 means no stall.
    task automatic expectBurst(input int side, input int tg, input int base, input bit isWr,
                               input int stallBeat, input int stallLen);
        int c;
        int reps;
        int acc [DEF_BURST];
        gntQ.push_back('{tg, side, 0, 0, 0});
        c = tg + 1;
        for (int b = 0; b < DEF_BURST; b++) begin
            reps = (b == stallBeat) ? stallLen + 1 : 1;
            for (int r = 0; r < reps; r++) begin
                memQ.push_back('{c, isWr ? 2 : 1, base + 2 * b, isWr ? (int'(16'hC000) + b) : 0,
                                 isWr ? b : 0});
                c++;
            end
            acc[b] = c - 1;
        end
        if (isWr) begin
            doneQ.push_back('{c, side, 0, 0, 0});
        end else begin
            for (int b = 0; b < DEF_BURST; b++) begin
                retQ.push_back('{acc[b] + DEF_MEM_LAT, side, b, (base + 2 * b) ^ int'(16'h5A5A), 0});
            end
            doneQ.push_back('{acc[DEF_BURST-1] + DEF_MEM_LAT + 1, side, 0, 0, 0});
        end
    endtask

    // Monitor: every presented grant/issue/return/done must match the next expected event.
    always @(negedge clk) begin
        ev_t e;
        if (i_gnt || d_gnt) begin
            if (gntQ.size() == 0) begin
                check("gnt_unexpected", int'({d_gnt, i_gnt}), 0);
            end else begin
                e = gntQ.pop_front();
                check("gnt_cycle", cyc, e.cyc);
                check("gnt_side", int'({d_gnt, i_gnt}), (e.a == 1) ? 2 : 1);
            end
        end
        if (mem_rd || mem_wr) begin
            if (memQ.size() == 0) begin
                check("mem_unexpected", int'({mem_wr, mem_rd}), 0);
            end else begin
                e = memQ.pop_front();
                check("mem_cycle", cyc, e.cyc);
                check("mem_kind", int'({mem_wr, mem_rd}), e.a);
                check("mem_addr", int'(mem_addr), e.b);
                check("d_wbeat", int'(d_wbeat), e.d);
                if (e.a == 2) check("mem_wdata", int'(mem_wdata), e.c);
            end
        end
        if (i_rvalid || d_rvalid) begin
            if (retQ.size() == 0) begin
                check("ret_unexpected", int'({d_rvalid, i_rvalid}), 0);
            end else begin
                e = retQ.pop_front();
                check("ret_cycle", cyc, e.cyc);
                check("ret_side", int'({d_rvalid, i_rvalid}), (e.a == 1) ? 2 : 1);
                check("ret_beat", int'({d_rbeat, i_rbeat}), (e.a == 1) ? (e.b << BEAT_W) : e.b);
                check("ret_data", int'({d_rdata, i_rdata}), (e.a == 1) ? (e.c << 16) : e.c);
            end
        end
        if (i_done || d_done) begin
            if (doneQ.size() == 0) begin
                check("done_unexpected", int'({d_done, i_done}), 0);
            end else begin
                e = doneQ.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("done_side", int'({d_done, i_done}), (e.a == 1) ? 2 : 1);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        i_req     = 1'b0;
        d_req     = 1'b0;
        d_wr      = 1'b0;
        i_addr    = 16'h0000;
        d_addr    = 16'h0000;
        mem_stall = 1'b0;
        #2;
        rst = 1'b0;
        repeat (3) tick();
        checkIdle("reset_outputs");
        rst = 1'b1;
        tick();

        // I read of line 0x1230, no stall
        i_addr = 16'h1236;
        i_req  = 1'b1;
        t = cyc;
        expectBurst(0, t, 'h1230, 1'b0, -1, 0);
        tick();
        i_req = 1'b0;
        repeat (8) tick();

        // Tie after reset, both requests held: D, I, D
        rst = 1'b0;
        tick();
        checkIdle("reset_pulse_outputs");
        tick();
        rst = 1'b1;
        tick();
        i_addr = 16'h2000;
        d_addr = 16'h3008;
        d_wr   = 1'b0;
        i_req  = 1'b1;
        d_req  = 1'b1;
        t = cyc;
        expectBurst(1, t,      'h3008, 1'b0, -1, 0);
        expectBurst(0, t + 8,  'h2000, 1'b0, -1, 0);
        expectBurst(1, t + 16, 'h3008, 1'b0, -1, 0);
        repeat (17) tick();
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (8) tick();

        // D write of 0x4000 with a 3-cycle stall on beat 2
        d_addr = 16'h4000;
        d_wr   = 1'b1;
        d_req  = 1'b1;
        t = cyc;
        expectBurst(1, t, 'h4000, 1'b1, 2, 3);
        tick();
        d_req = 1'b0;
        tick();
        tick();
        mem_stall = 1'b1;
        repeat (3) tick();
        mem_stall = 1'b0;
        repeat (4) tick();

        // D read aborted by reset in DRAIN after two returns
        d_addr = 16'h5000;
        d_wr   = 1'b0;
        d_req  = 1'b1;
        t = cyc;
        gntQ.push_back('{t, 1, 0, 0, 0});
        for (int b = 0; b < DEF_BURST; b++) memQ.push_back('{t + 1 + b, 1, 'h5000 + 2 * b, 0, 0});
        retQ.push_back('{t + 3, 1, 0, 'h5000 ^ 'h5A5A, 0});
        retQ.push_back('{t + 4, 1, 1, 'h5002 ^ 'h5A5A, 0});
        tick();
        d_req = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        #1;
        checkIdle("reset_async_outputs");
        tick();
        tick();
        rst = 1'b1;
        tick();
        i_addr = 16'h6000;
        i_req  = 1'b1;
        t = cyc;
        expectBurst(0, t, 'h6000, 1'b0, -1, 0);
        tick();
        i_req = 1'b0;
        repeat (8) tick();

        // D read at the top of the address space
        d_addr = 16'hFFFE;
        d_wr   = 1'b0;
        d_req  = 1'b1;
        t = cyc;
        expectBurst(1, t, 'hFFF8, 1'b0, -1, 0);
        tick();
        d_req = 1'b0;
        repeat (8) tick();

        // I request held: back-to-back bursts
        i_addr = 16'h0ABC;
        i_req  = 1'b1;
        t = cyc;
        expectBurst(0, t,     'h0AB8, 1'b0, -1, 0);
        expectBurst(0, t + 8, 'h0AB8, 1'b0, -1, 0);
        repeat (9) tick();
        i_req = 1'b0;
        repeat (10) tick();

        check("leftover_events", gntQ.size() + memQ.size() + retQ.size() + doneQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
